// File: rtl/vm_dispatch_arbiter.sv
// Round-robin, packet-granular arbiter sharing one snooper and one forwarder
// among N BPF VMs. Each side owns an independent SEEK/ACTIVE lock FSM.

module vm_dispatch_lock #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             axi_aclk,
  input  logic             resetn,
  input  logic [N-1:0]     vm_ready,
  input  logic             done,
  output logic             active,
  output logic [IDX_W-1:0] sel,
  output logic [31:0]      count
);

  typedef enum logic {SEEK, ACTIVE} state_t;

  localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);

  state_t                state, state_nx;
  logic [IDX_W-1:0]      ptr, ptr_nx, sel_nx, pick;
  logic [31:0]           count_nx;
  logic                  found;
  logic [IDX_W:0]        cand, sel_sum;
  logic [2**IDX_W-1:0]   ready_ext;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge axi_aclk or negedge resetn) begin
    if (!resetn) begin
      state <= SEEK;
      ptr   <= '0;
      sel   <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      sel   <= sel_nx;
      count <= count_nx;
    end
  end

  // First ready VM scanning ptr, ptr+1, ... wrapping mod N.
  always_comb begin
    found     = 1'b0;
    pick      = '0;
    cand      = '0;
    ready_ext = (2**IDX_W)'(vm_ready);
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= N_W) cand = cand - N_W;
      if (!found && ready_ext[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDX_W-1:0];
      end
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    sel_nx   = sel;
    count_nx = count;
    sel_sum  = {1'b0, sel} + (IDX_W+1)'(1);
    case (state)
      SEEK: begin
        if (found) begin
          sel_nx   = pick;
          state_nx = ACTIVE;
        end
      end
      ACTIVE: begin
        if (done) begin
          ptr_nx   = (sel_sum >= N_W) ? '0 : sel_sum[IDX_W-1:0];
          state_nx = SEEK;
          count_nx = count + 32'd1;
        end
      end
      default: state_nx = SEEK;
    endcase
  end

  assign active = (state == ACTIVE);

endmodule

module vm_dispatch_arbiter #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9,
  parameter int PLEN_WIDTH = ADDR_WIDTH + 1,
  parameter int IDX_W      = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    axi_aclk,
  input  logic                    resetn,
  input  logic [ADDR_WIDTH-1:0]   snooper_wr_addr,
  input  logic [DATA_WIDTH-1:0]   snooper_wr_data,
  input  logic                    snooper_wr_en,
  input  logic                    snooper_done,
  output logic                    ready_for_snooper,
  output logic [ADDR_WIDTH-1:0]   vm_wr_addr,
  output logic [DATA_WIDTH-1:0]   vm_wr_data,
  output logic [N-1:0]            vm_wr_en,
  output logic [N-1:0]            vm_snoop_done,
  input  logic [N-1:0]            vm_ready_for_snooper,
  input  logic [ADDR_WIDTH-1:0]   forwarder_rd_addr,
  input  logic                    forwarder_rd_en,
  input  logic                    forwarder_done,
  output logic [DATA_WIDTH-1:0]   forwarder_rd_data,
  output logic [PLEN_WIDTH-1:0]   len_to_forwarder,
  output logic                    ready_for_forwarder,
  output logic [ADDR_WIDTH-1:0]   vm_rd_addr,
  output logic [N-1:0]            vm_rd_en,
  output logic [N-1:0]            vm_fwd_done,
  input  logic [N*DATA_WIDTH-1:0] vm_rd_data,
  input  logic [N*PLEN_WIDTH-1:0] vm_len,
  input  logic [N-1:0]            vm_ready_for_forwarder,
  output logic [IDX_W-1:0]        snoop_sel,
  output logic [IDX_W-1:0]        fwd_sel,
  output logic [31:0]             pkts_in,
  output logic [31:0]             pkts_out
);

  logic                  s_active, f_active;
  logic                  s_ready, f_ready;
  logic [N-1:0]          s_onehot, f_onehot;
  logic [DATA_WIDTH-1:0] f_data;
  logic [PLEN_WIDTH-1:0] f_len;

  // Done is gated by the lock, so strobes arriving in SEEK never count.
  vm_dispatch_lock #(.N(N), .IDX_W(IDX_W)) u_snoop (
    .axi_aclk (axi_aclk),
    .resetn   (resetn),
    .vm_ready (vm_ready_for_snooper),
    .done     (snooper_done),
    .active   (s_active),
    .sel      (snoop_sel),
    .count    (pkts_in)
  );

  vm_dispatch_lock #(.N(N), .IDX_W(IDX_W)) u_fwd (
    .axi_aclk (axi_aclk),
    .resetn   (resetn),
    .vm_ready (vm_ready_for_forwarder),
    .done     (forwarder_done),
    .active   (f_active),
    .sel      (fwd_sel),
    .count    (pkts_out)
  );

  // Slice selection by comparison keeps every index in range for any N.
  always_comb begin
    s_ready  = 1'b0;
    f_ready  = 1'b0;
    s_onehot = '0;
    f_onehot = '0;
    f_data   = '0;
    f_len    = '0;
    for (int k = 0; k < N; k++) begin
      if (snoop_sel == IDX_W'(k)) begin
        s_ready     = vm_ready_for_snooper[k];
        s_onehot[k] = 1'b1;
      end
      if (fwd_sel == IDX_W'(k)) begin
        f_ready     = vm_ready_for_forwarder[k];
        f_onehot[k] = 1'b1;
        f_data      = vm_rd_data[k*DATA_WIDTH +: DATA_WIDTH];
        f_len       = vm_len[k*PLEN_WIDTH +: PLEN_WIDTH];
      end
    end
  end

  assign ready_for_snooper   = s_active & s_ready;
  assign vm_wr_en            = (s_active && snooper_wr_en)   ? s_onehot : '0;
  assign vm_snoop_done       = (s_active && snooper_done)    ? s_onehot : '0;

  assign ready_for_forwarder = f_active & f_ready;
  assign vm_rd_en            = (f_active && forwarder_rd_en) ? f_onehot : '0;
  assign vm_fwd_done         = (f_active && forwarder_done)  ? f_onehot : '0;
  assign forwarder_rd_data   = f_active ? f_data : '0;
  assign len_to_forwarder    = f_active ? f_len  : '0;

  // Broadcast buses follow their inputs but read as zero while in reset.
  assign vm_wr_addr = resetn ? snooper_wr_addr   : '0;
  assign vm_wr_data = resetn ? snooper_wr_data   : '0;
  assign vm_rd_addr = resetn ? forwarder_rd_addr : '0;

endmodule

// File: tb/tb_vm_dispatch_arbiter.sv
// Bench for vm_dispatch_arbiter: directed scenarios with literal expectations,
// then random traffic checked every cycle against a packet-level lock model.

module tb_vm_dispatch_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int AW = 9;
  localparam int PW = 10;
  localparam int IW = 2;

  logic            axi_aclk = 1'b0;
  logic            resetn   = 1'b0;
  logic [AW-1:0]   snooper_wr_addr = '0;
  logic [DW-1:0]   snooper_wr_data = '0;
  logic            snooper_wr_en = 1'b0, snooper_done = 1'b0;
  logic            ready_for_snooper;
  logic [AW-1:0]   vm_wr_addr;
  logic [DW-1:0]   vm_wr_data;
  logic [N-1:0]    vm_wr_en, vm_snoop_done;
  logic [N-1:0]    vm_ready_for_snooper = '0;
  logic [AW-1:0]   forwarder_rd_addr = '0;
  logic            forwarder_rd_en = 1'b0, forwarder_done = 1'b0;
  logic [DW-1:0]   forwarder_rd_data;
  logic [PW-1:0]   len_to_forwarder;
  logic            ready_for_forwarder;
  logic [AW-1:0]   vm_rd_addr;
  logic [N-1:0]    vm_rd_en, vm_fwd_done;
  logic [N*DW-1:0] vm_rd_data = '0;
  logic [N*PW-1:0] vm_len = '0;
  logic [N-1:0]    vm_ready_for_forwarder = '0;
  logic [IW-1:0]   snoop_sel, fwd_sel;
  logic [31:0]     pkts_in, pkts_out;

  vm_dispatch_arbiter #(
    .N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PLEN_WIDTH(PW), .IDX_W(IW)
  ) dut (
    .axi_aclk(axi_aclk), .resetn(resetn),
    .snooper_wr_addr(snooper_wr_addr), .snooper_wr_data(snooper_wr_data),
    .snooper_wr_en(snooper_wr_en), .snooper_done(snooper_done),
    .ready_for_snooper(ready_for_snooper),
    .vm_wr_addr(vm_wr_addr), .vm_wr_data(vm_wr_data),
    .vm_wr_en(vm_wr_en), .vm_snoop_done(vm_snoop_done),
    .vm_ready_for_snooper(vm_ready_for_snooper),
    .forwarder_rd_addr(forwarder_rd_addr), .forwarder_rd_en(forwarder_rd_en),
    .forwarder_done(forwarder_done), .forwarder_rd_data(forwarder_rd_data),
    .len_to_forwarder(len_to_forwarder), .ready_for_forwarder(ready_for_forwarder),
    .vm_rd_addr(vm_rd_addr), .vm_rd_en(vm_rd_en), .vm_fwd_done(vm_fwd_done),
    .vm_rd_data(vm_rd_data), .vm_len(vm_len),
    .vm_ready_for_forwarder(vm_ready_for_forwarder),
    .snoop_sel(snoop_sel), .fwd_sel(fwd_sel),
    .pkts_in(pkts_in), .pkts_out(pkts_out)
  );

  always #5 axi_aclk = ~axi_aclk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level model: each side is either locked to a VM (lock >= 0) or seeking.
  int          s_lock = -1, s_ptr = 0, s_sel = 0;
  int          f_lock = -1, f_ptr = 0, f_sel = 0;
  logic [31:0] m_in = '0, m_out = '0;

  function automatic int first_ready(input int ptr, input logic [N-1:0] rdy);
    for (int i = 0; i < N; i++)
      if (rdy[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  initial forever begin
    logic [N-1:0]  one;
    logic [N-1:0]  e_wr, e_sd, e_rd, e_fd;
    logic          e_sr, e_fr;
    logic [DW-1:0] e_data;
    logic [PW-1:0] e_len;
    int            k;
    @(negedge axi_aclk);
    one = 1;
    if (!resetn) begin
      s_lock = -1; s_ptr = 0; s_sel = 0;
      f_lock = -1; f_ptr = 0; f_sel = 0;
      m_in = '0; m_out = '0;
    end
    e_wr = '0; e_sd = '0; e_sr = 1'b0;
    e_rd = '0; e_fd = '0; e_fr = 1'b0; e_data = '0; e_len = '0;
    if (s_lock >= 0) begin
      e_sr = vm_ready_for_snooper[s_lock];
      if (snooper_wr_en) e_wr = one << s_lock;
      if (snooper_done)  e_sd = one << s_lock;
    end
    if (f_lock >= 0) begin
      e_fr   = vm_ready_for_forwarder[f_lock];
      e_data = vm_rd_data[f_lock*DW +: DW];
      e_len  = vm_len[f_lock*PW +: PW];
      if (forwarder_rd_en) e_rd = one << f_lock;
      if (forwarder_done)  e_fd = one << f_lock;
    end
    check("ready_for_snooper", ready_for_snooper, e_sr);
    check("vm_wr_en", vm_wr_en, e_wr);
    check("vm_snoop_done", vm_snoop_done, e_sd);
    check("snoop_sel", snoop_sel, s_sel);
    check("pkts_in", pkts_in, m_in);
    check("vm_wr_addr", vm_wr_addr, resetn ? snooper_wr_addr : '0);
    check("vm_wr_data", vm_wr_data, resetn ? snooper_wr_data : '0);
    check("ready_for_forwarder", ready_for_forwarder, e_fr);
    check("vm_rd_en", vm_rd_en, e_rd);
    check("vm_fwd_done", vm_fwd_done, e_fd);
    check("forwarder_rd_data", forwarder_rd_data, e_data);
    check("len_to_forwarder", len_to_forwarder, e_len);
    check("fwd_sel", fwd_sel, f_sel);
    check("pkts_out", pkts_out, m_out);
    check("vm_rd_addr", vm_rd_addr, resetn ? forwarder_rd_addr : '0);
    // Advance the model to the state the next rising edge establishes.
    if (resetn) begin
      if (s_lock < 0) begin
        k = first_ready(s_ptr, vm_ready_for_snooper);
        if (k >= 0) begin s_lock = k; s_sel = k; end
      end else if (snooper_done) begin
        s_ptr = (s_lock + 1) % N; s_lock = -1; m_in = m_in + 1;
      end
      if (f_lock < 0) begin
        k = first_ready(f_ptr, vm_ready_for_forwarder);
        if (k >= 0) begin f_lock = k; f_sel = k; end
      end else if (forwarder_done) begin
        f_ptr = (f_lock + 1) % N; f_lock = -1; m_out = m_out + 1;
      end
    end
  end

  task automatic step();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic clear_strobes();
    snooper_wr_en = 1'b0; snooper_done = 1'b0;
    forwarder_rd_en = 1'b0; forwarder_done = 1'b0;
  endtask

  task automatic do_reset();
    step();
    resetn = 1'b0;
    clear_strobes();
    vm_ready_for_snooper = '0;
    vm_ready_for_forwarder = '0;
    step();
    resetn = 1'b1;
  endtask

  task automatic wait_sready();
    int n = 0;
    @(negedge axi_aclk);
    while (!ready_for_snooper && n < 10) begin @(negedge axi_aclk); n++; end
    check("snoop_lock_wait", ready_for_snooper, 1'b1);
  endtask

  task automatic wait_fready();
    int n = 0;
    @(negedge axi_aclk);
    while (!ready_for_forwarder && n < 10) begin @(negedge axi_aclk); n++; end
    check("fwd_lock_wait", ready_for_forwarder, 1'b1);
  endtask

  task automatic pulse_sdone();
    step(); snooper_done = 1'b1;
    step(); snooper_done = 1'b0;
  endtask

  initial begin
    int seq [5] = '{0, 1, 2, 3, 0};
    int alt [3] = '{1, 3, 1};
    step();
    resetn = 1'b1;

    // All VMs ready: strict rotation, one SEEK cycle after each done.
    do_reset();
    vm_ready_for_snooper = 4'b1111;
    for (int p = 0; p < 5; p++) begin
      wait_sready();
      step(); snooper_done = 1'b1; snooper_wr_en = 1'b1;
      @(negedge axi_aclk);
      check("rot_done_route", vm_snoop_done, 4'b0001 << seq[p]);
      check("rot_wr_route", vm_wr_en, 4'b0001 << seq[p]);
      step(); snooper_done = 1'b0; snooper_wr_en = 1'b0;
      @(negedge axi_aclk);
      check("rot_seek_gap", ready_for_snooper, 1'b0);
      @(negedge axi_aclk);
      check("rot_relock", ready_for_snooper, 1'b1);
    end
    check("rot_pkts_in", pkts_in, 32'd5);

    // Sparse readiness skips idle VMs.
    do_reset();
    vm_ready_for_snooper = 4'b1010;
    for (int p = 0; p < 3; p++) begin
      wait_sready();
      check("sparse_sel", snoop_sel, alt[p]);
      pulse_sdone();
    end

    // Nobody ready: strobes are dropped until VM2 comes up.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(); snooper_wr_en = 1'b1; snooper_done = i[0];
      @(negedge axi_aclk);
      check("idle_no_wr", vm_wr_en, 4'b0000);
      check("idle_not_ready", ready_for_snooper, 1'b0);
    end
    step(); clear_strobes(); vm_ready_for_snooper = 4'b0100;
    @(negedge axi_aclk);
    check("idle_still_seek", ready_for_snooper, 1'b0);
    @(negedge axi_aclk);
    check("idle_lock_sel", snoop_sel, 2'd2);
    check("idle_lock_ready", ready_for_snooper, 1'b1);
    check("idle_pkts_in", pkts_in, 32'd0);

    // Forward side selects slice 2's length and data.
    do_reset();
    for (int k = 0; k < N; k++) begin
      vm_rd_data[k*DW +: DW] = {$urandom, $urandom};
      vm_len[k*PW +: PW] = PW'($urandom);
    end
    vm_rd_data[2*DW +: DW] = 64'hDEAD;
    vm_len[2*PW +: PW] = 10'd60;
    vm_ready_for_forwarder = 4'b0100;
    wait_fready();
    check("fwd_len", len_to_forwarder, 10'd60);
    check("fwd_data", forwarder_rd_data, 64'hDEAD);
    step(); forwarder_rd_en = 1'b1;
    @(negedge axi_aclk);
    check("fwd_rd_en", vm_rd_en, 4'b0100);
    step(); forwarder_rd_en = 1'b0; forwarder_done = 1'b1;
    @(negedge axi_aclk);
    check("fwd_done", vm_fwd_done, 4'b0100);
    step(); forwarder_done = 1'b0;
    @(negedge axi_aclk);
    check("fwd_pkts_out", pkts_out, 32'd1);

    // Both sides locked to VM2 at once.
    do_reset();
    vm_ready_for_snooper = 4'b0100;
    vm_ready_for_forwarder = 4'b0100;
    wait_sready();
    wait_fready();
    step(); snooper_done = 1'b1; forwarder_done = 1'b1;
    @(negedge axi_aclk);
    check("dual_snoop_done", vm_snoop_done, 4'b0100);
    check("dual_fwd_done", vm_fwd_done, 4'b0100);
    step(); clear_strobes();
    @(negedge axi_aclk);
    check("dual_pkts_in", pkts_in, 32'd1);
    check("dual_pkts_out", pkts_out, 32'd1);

    // Reset mid-packet clears everything at once; arbitration restarts at VM0.
    do_reset();
    vm_ready_for_snooper = 4'b1111;
    wait_sready();
    pulse_sdone();
    wait_sready();
    check("rst_pre_sel", snoop_sel, 2'd1);
    step(); snooper_wr_en = 1'b1; resetn = 1'b0;
    #1;
    check("rst_async_ready", ready_for_snooper, 1'b0);
    check("rst_async_wr", vm_wr_en, 4'b0000);
    check("rst_async_sel", snoop_sel, 2'd0);
    check("rst_async_cnt", pkts_in, 32'd0);
    step(); resetn = 1'b1; snooper_wr_en = 1'b0;
    wait_sready();
    check("rst_restart_sel", snoop_sel, 2'd0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step();
      resetn = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 5) == 0) vm_ready_for_snooper = N'($urandom);
      if ($urandom_range(0, 5) == 0) vm_ready_for_forwarder = N'($urandom);
      snooper_wr_en   = $urandom_range(0, 1) == 1;
      snooper_done    = $urandom_range(0, 3) == 0;
      forwarder_rd_en = $urandom_range(0, 1) == 1;
      forwarder_done  = $urandom_range(0, 3) == 0;
      snooper_wr_addr   = AW'($urandom);
      snooper_wr_data   = {$urandom, $urandom};
      forwarder_rd_addr = AW'($urandom);
      for (int k = 0; k < N; k++) begin
        vm_rd_data[k*DW +: DW] = {$urandom, $urandom};
        vm_len[k*PW +: PW] = PW'($urandom);
      end
    end
    step(); clear_strobes(); resetn = 1'b1;
    @(negedge axi_aclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vm_dispatch_arbiter.md
Name: vm_dispatch_arbiter

Overview:
- Round-robin scheduler sharing one snooper and one forwarder among N parallel BPF VMs.
- Replaces the static split/combine trees when fair, packet-granular sharing is needed.
- Snoop side: locks to one ready VM per packet and routes wr_en/done only to it.
- Forward side: locks to one VM holding an accepted packet, muxes its read data and length back, releases on forwarder_done.

Parameters:
- N, 4: number of VMs; legal range 1..16.
- DATA_WIDTH, 64: snooper/forwarder data width.
- ADDR_WIDTH, 9: snooper/forwarder address width.
- PLEN_WIDTH, 10: packet length width (ADDR_WIDTH+1).
- IDX_W, 2: VM index width, max(1, clog2(N)).

Ports:
- axi_aclk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- snooper_wr_addr  in  ADDR_WIDTH  upstream write address.
- snooper_wr_data  in  DATA_WIDTH  upstream write data.
- snooper_wr_en  in  1  upstream write strobe.
- snooper_done  in  1  1-cycle end-of-packet pulse.
- ready_for_snooper  out  1  locked VM can accept writes.
- vm_wr_addr  out  ADDR_WIDTH  broadcast to all VMs.
- vm_wr_data  out  DATA_WIDTH  broadcast to all VMs.
- vm_wr_en  out  N  one-hot write strobe.
- vm_snoop_done  out  N  one-hot done pulse.
- vm_ready_for_snooper  in  N  per-VM ready.
- forwarder_rd_addr  in  ADDR_WIDTH  upstream read address.
- forwarder_rd_en  in  1  upstream read strobe.
- forwarder_done  in  1  1-cycle end-of-packet pulse.
- forwarder_rd_data  out  DATA_WIDTH  muxed read data.
- len_to_forwarder  out  PLEN_WIDTH  muxed packet length.
- ready_for_forwarder  out  1  locked VM has a packet.
- vm_rd_addr  out  ADDR_WIDTH  broadcast to all VMs.
- vm_rd_en  out  N  one-hot read strobe.
- vm_fwd_done  out  N  one-hot done pulse.
- vm_rd_data  in  N*DATA_WIDTH  packed; VM k at [k*DATA_WIDTH +: DATA_WIDTH].
- vm_len  in  N*PLEN_WIDTH  packed, same layout.
- vm_ready_for_forwarder  in  N  per-VM ready.
- snoop_sel  out  IDX_W  current snoop lock (debug).
- fwd_sel  out  IDX_W  current forward lock (debug).
- pkts_in  out  32  count of snooper_done accepted.
- pkts_out  out  32  count of forwarder_done accepted.

Behaviour:
- Two independent FSMs, each with states SEEK and ACTIVE, plus a registered pointer ptr and a registered lock index sel.
- Reset (asynchronous, resetn=0) forces both FSMs to SEEK, ptr=0, sel=0 and both counters to 0.
- Reset value of all outputs is 0, including every vm_* vector. Broadcast address/data outputs are combinational from their inputs.
- SEEK:
  - Find the first k in order ptr, ptr+1, …, wrapping mod N, with the corresponding vm_ready bit high.
  - If found: sel<=k and go to ACTIVE next cycle. Scheduling latency is 1 cycle.
  - If none found: stay in SEEK.
  - The upstream ready output is 0 in SEEK.
- ACTIVE:
  - ready_for_snooper = vm_ready_for_snooper[sel] (combinational); ready_for_forwarder = vm_ready_for_forwarder[sel].
  - vm_wr_en[sel] = snooper_wr_en and vm_snoop_done[sel] = snooper_done. All other bits are 0.
  - Forward side mirrors this: vm_rd_en and vm_fwd_done route to sel; forwarder_rd_data and len_to_forwarder are selected from slice sel.
- Done is combinational pass-through, zero added latency.
- On done in ACTIVE: ptr <= (sel+1) mod N, state <= SEEK, and the counter increments.
- Strobes arriving in SEEK are dropped: no vm_* bit asserts and the counter does not change.
- If the locked VM drops ready while in ACTIVE without a done, the FSM stays locked. The upstream ready output follows the VM ready; there is no reselection mid-packet.
- In SEEK, forwarder_rd_data and len_to_forwarder are 0.
- The snoop and forward FSMs may lock the same VM at once; they do not interact.
- Counters wrap modulo 2^32.
- N=1: ptr and sel are always 0. Behaviour reduces to pass-through gated by one cycle of SEEK per packet.
- Reset mid-packet aborts the lock. No done pulse is generated toward the VM.

Test Plan:
- N=4, all vm_ready_for_snooper=1, send 5 packets (done pulses): vm_snoop_done bit sequence is 0,1,2,3,0; pkts_in=5; ready_for_snooper low exactly 1 cycle after each done.
- vm_ready_for_snooper=4'b1010, ptr=0: locks VM1; after its done, locks VM3; after that done, locks VM1.
- All ready=0: 20 cycles in SEEK with ready_for_snooper=0; snooper_wr_en pulses produce vm_wr_en=0 and pkts_in unchanged; raising VM2 ready gives ACTIVE with sel=2 one cycle later.
- Forward side, vm_ready_for_forwarder=4'b0100, vm_len slice 2=60, rd_data slice 2=0xDEAD: len_to_forwarder=60, rd_data=0xDEAD, forwarder_rd_en drives only vm_rd_en[2]; done gives vm_fwd_done=4'b0100 and pkts_out+1.
- Snoop locked to VM2 and forward locked to VM2 simultaneously: both done pulses route independently; both counters +1 in the same cycle.
- resetn low mid-packet in ACTIVE: all outputs 0 immediately (asynchronous); after release, arbitration restarts from VM0.
